dmem_mc: RTL and testbench

DMEM_MC -- requirements
Module: dmem_mc

---
 rtl/dmem_mc.sv | 162 ++++++++++++++++
 tb/tb_dmem_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mc.sv
// dmem_mc: single-port 32-bit data memory with a byte/half/word load-store
// front end. It accepts one request at a time through a fixed three-state
// sequence (IDLE -> ACCESS -> RESP). A request handshaken in cycle T returns
// a one-cycle response in cycle T+2. The next request can be accepted no
// earlier than cycle T+3.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE with rst low)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned      zero-extend (1) or sign-extend (0) sub-word loads
//   req_addr          byte address; [ADDR_W+1:2] selects the word, [1:0] the lane
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle response pulse
//   resp_rdata        load result (0 for stores, errors and when idle)
//   resp_err          misaligned or reserved-size access
module dmem_mc #(
  parameter int ADDR_W    = 10,
  parameter bit ZERO_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Contents are defined only by stores. Reset never touches the array.
  logic [31:0] mem [DEPTH] = '{default: (ZERO_INIT ? 32'h0 : 32'hx)};

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        off;
  logic              acc_err;
  logic [31:0]       rd_word, rd_shift, ld_val, wr_word;
  logic [15:0]       ld_half;
  logic [3:0]        wr_lane_en;
  logic              mem_we;

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;

  // Datapath: all decode uses the captured request, never the live inputs.
  always_comb begin
    word_idx = addr_q[ADDR_W+1:2];
    off      = addr_q[1:0];
    acc_err  = (size_q == 2'b11) ||
               ((size_q == 2'b01) && off[0]) ||
               ((size_q == 2'b10) && (off != 2'b00));

    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {off, 3'b000};
    ld_half  = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   ld_val = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_val = rd_word;
    endcase

    // Replicate store data across lanes so each lane enable picks its own copy.
    case (size_q)
      2'b00:   begin wr_word = {4{wdata_q[7:0]}};  wr_lane_en = 4'b0001 << off; end
      2'b01:   begin wr_word = {2{wdata_q[15:0]}}; wr_lane_en = off[1] ? 4'b1100 : 4'b0011; end
      2'b10:   begin wr_word = wdata_q;            wr_lane_en = 4'b1111; end
      default: begin wr_word = wdata_q;            wr_lane_en = 4'b0000; end
    endcase

    // A reset landing in ACCESS cancels the pending store.
    mem_we = (state_q == S_ACCESS) && !rst && we_q && !acc_err;
  end

  // Control: the response is registered at the end of ACCESS and shown in RESP.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_ACCESS;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      S_ACCESS: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = acc_err;
        rdata_d      = (!we_q && !acc_err) ? ld_val : 32'h0;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lane_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_mc.sv
// Directed plus randomized checks of dmem_mc against a byte-array memory model.
module tb_dmem_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int hs_q[$];
  int hs_all[$];

  // Reference memory: 4 KiB of bytes, little-endian multi-byte accesses.
  logic [7:0] mb [4096];

  dmem_mc #(.ADDR_W(10), .ZERO_INIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_err(input logic [1:0] sz, input logic [11:0] a);
    if (sz == 2'b11) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u, input logic [11:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a + 12'(i)];
    if (!u && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) mb[a + 12'(i)] = d[8*i +: 8];
  endtask

  // Latency monitor: every response must come exactly 2 cycles after its handshake.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      hs_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        hs_q.push_back(cyc);
        hs_all.push_back(cyc);
      end
      if (resp_valid) begin
        if (hs_q.size() == 0) chk("resp_without_req", 32'(hs_q.size()), 32'd1);
        else begin
          int t;
          t = hs_q.pop_front();
          chk("latency", 32'(cyc - t), 32'd2);
        end
      end
    end
  end

  // One full request; returns at #1 into cycle T+3. Inputs are scrambled after
  // the handshake to confirm the captured request is used.
  task automatic txn(input logic we, input logic [1:0] sz, input logic u,
                     input logic [11:0] a, input logic [31:0] wd,
                     output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    exp_e = m_err(sz, a);
    exp_d = 32'h0;
    if (!exp_e) begin
      if (we) m_store(sz, a, wd);
      else    exp_d = m_load(sz, u, a);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = 12'($urandom); req_wdata = $urandom;
    chk("access_no_resp", 32'(resp_valid), 32'd0);
    chk("access_not_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, exp_d);
    chk("resp_err", 32'(resp_err), 32'(exp_e));
    got_d = resp_rdata;
    got_e = resp_err;
    @(posedge clk); #1;
    chk("resp_pulse_end", 32'(resp_valid), 32'd0);
    chk("rdata_idle_zero", resp_rdata, 32'h0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;

    // Reset: nothing ready, outputs quiet, even with req_valid asserted.
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1 chk("ready_out_of_rst", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Word store/load round trip.
    txn(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, d, e);
    txn(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, d, e);
    chk("lw_010", d, 32'hDEADBEEF);

    // Byte store into lane 2, then sub-word loads with both extensions.
    txn(1'b1, 2'b00, 1'b0, 12'h012, 32'h00000055, d, e);
    txn(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, d, e);
    chk("lw_after_sb", d, 32'hDE55BEEF);
    txn(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, d, e);
    chk("lb_013", d, 32'hFFFFFFDE);
    txn(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, d, e);
    chk("lbu_013", d, 32'h000000DE);
    txn(1'b0, 2'b01, 1'b0, 12'h012, 32'h0, d, e);
    chk("lh_012", d, 32'hFFFFDE55);
    txn(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, d, e);
    chk("lhu_012", d, 32'h0000DE55);
    txn(1'b0, 2'b01, 1'b0, 12'h011, 32'h0, d, e);
    chk("lh_011_err", 32'(e), 32'd1);

    // Misaligned word store and reserved size must not write.
    txn(1'b1, 2'b10, 1'b0, 12'h022, 32'h12345678, d, e);
    chk("sw_022_err", 32'(e), 32'd1);
    txn(1'b1, 2'b11, 1'b0, 12'h020, 32'h12345678, d, e);
    chk("s11_err", 32'(e), 32'd1);
    txn(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, d, e);
    chk("lw_020_unchanged", d, 32'h0);

    // Reset during ACCESS drops the store and its response.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 12'h030; req_wdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc_ready", 32'(req_ready), 32'd0);
    chk("rst_acc_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst_acc_resp2", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    #1 chk("rst_acc_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_acc_resp3", 32'(resp_valid), 32'd0);
    txn(1'b0, 2'b10, 1'b0, 12'h030, 32'h0, d, e);
    chk("lw_030_not_written", d, 32'h0);

    // Top word of the array.
    txn(1'b1, 2'b10, 1'b0, 12'hFFC, 32'hCAFEF00D, d, e);
    txn(1'b1, 2'b00, 1'b0, 12'hFFF, 32'h00000081, d, e);
    txn(1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0, d, e);
    chk("lw_ffc", d, 32'h81FEF00D);

    // req_valid held high: handshakes every third cycle.
    hs_all.delete();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 12'h010;
    repeat (10) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_count", 32'(hs_all.size()), 32'd4);
    for (int i = 1; i < hs_all.size(); i++)
      chk("b2b_gap", 32'(hs_all[i] - hs_all[i-1]), 32'd3);

    // Randomized traffic over a few low words and the top words.
    for (int k = 0; k < 60; k++) begin
      logic [11:0] a;
      a = {($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 2'($urandom), 2'($urandom)};
      txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, d, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
